// File: rtl/mem_map_pkg.sv
// Shared memory-map constants and FSM encoding for the core data-bus controller.
package mem_map_pkg;

  localparam logic [7:0] IO_PAGE_DEF = 8'hFF;

  localparam logic [7:0] IO_TX   = 8'h00;
  localparam logic [7:0] IO_STAT = 8'h01;
  localparam logic [7:0] IO_IN   = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Status register layout: bit0 = FIFO full, bit1 = FIFO empty.
  function automatic logic [7:0] stat_byte(input logic full, input logic empty);
    return {6'b0, empty, full};
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous FIFO; a pop frees a slot for a same-cycle push when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic             w_push;
  logic             w_pop;

  assign empty  = (r_cnt == '0);
  assign full   = (r_cnt == CW'(DEPTH));
  assign w_pop  = pop & ~empty;
  assign w_push = push & (~full | w_pop);
  assign dout   = r_mem[r_rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= din;
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-wide controller for the core data bus: decodes RAM, MMIO page and
// unmapped space, and holds the core with m_wait until each access completes.
module mem_ctrl
  import mem_map_pkg::*;
#(
  parameter int unsigned ADR_MSB     = 15,
  parameter int unsigned RAM_AW      = 12,
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [7:0]  IO_PAGE     = IO_PAGE_DEF,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_cs,
  input  logic             m_we,
  input  logic [ADR_MSB:0] m_addr,
  input  logic [7:0]       m_odata,
  output logic [7:0]       m_idata,
  output logic             m_wait,
  input  logic [7:0]       io_in,
  output logic [7:0]       io_tx_data,
  output logic             io_tx_valid,
  input  logic             io_tx_ready
);

  localparam int unsigned      CNT_W     = 4;
  localparam int unsigned      PG_W      = ADR_MSB - 7;
  localparam int unsigned      RAM_DEPTH = 1 << RAM_AW;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADR_MSB:0]   r_addr;
  logic               r_we;
  logic [7:0]         r_wdata;
  logic [7:0]         r_ram_q;
  logic [7:0]         r_ram [RAM_DEPTH];

  logic               w_is_ram;
  logic               w_is_io;
  logic [7:0]         w_off;
  logic               w_tx_wr;
  logic               w_full;
  logic               w_empty;
  logic               w_push;
  logic               w_pop;
  logic [7:0]         w_rdata;

  // RAM wins if the MMIO page is ever parameterised to overlap it.
  function automatic logic tx_write(input logic [ADR_MSB:0] a, input logic we);
    return we && (a[ADR_MSB:RAM_AW] != '0) &&
           (a[ADR_MSB:8] == PG_W'(IO_PAGE)) && (a[7:0] == IO_TX);
  endfunction

  assign w_is_ram = (r_addr[ADR_MSB:RAM_AW] == '0);
  assign w_is_io  = ~w_is_ram && (r_addr[ADR_MSB:8] == PG_W'(IO_PAGE));
  assign w_off    = r_addr[7:0];
  assign w_tx_wr  = tx_write(r_addr, r_we);

  assign m_wait      = rst | (m_cs & (r_state != ST_DONE));
  assign io_tx_valid = ~w_empty;
  assign w_pop       = io_tx_valid & io_tx_ready;
  assign w_push      = (r_state == ST_DONE) & w_tx_wr;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_wdata),
    .dout  (io_tx_data),
    .full  (w_full),
    .empty (w_empty)
  );

  // Access sequencer; a TX write to a full FIFO parks in WAIT until a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (m_cs) begin
            r_addr  <= m_addr;
            r_we    <= m_we;
            r_wdata <= m_odata;
            if ((WAIT_STATES == 0) && !(tx_write(m_addr, m_we) && w_full)) begin
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= (WAIT_STATES == 0) ? CNT_ONE : CNT_W'(WAIT_STATES);
              r_state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!m_cs) begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end else if (r_cnt > CNT_ONE) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else if (!(w_tx_wr && w_full)) begin
            r_cnt   <= '0;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Synchronous RAM: read issued on capture, write committed at the DONE edge.
  always_ff @(posedge clk) begin
    if ((r_state == ST_IDLE) && m_cs) r_ram_q <= r_ram[m_addr[RAM_AW-1:0]];
    if ((r_state == ST_DONE) && r_we && w_is_ram) r_ram[r_addr[RAM_AW-1:0]] <= r_wdata;
  end

  always_comb begin
    w_rdata = 8'h00;
    if (w_is_ram) begin
      w_rdata = r_ram_q;
    end else if (w_is_io) begin
      case (w_off)
        IO_STAT: w_rdata = stat_byte(w_full, w_empty);
        IO_IN:   w_rdata = io_in;
        default: w_rdata = 8'h00;
      endcase
    end
  end

  assign m_idata = (r_state == ST_DONE) ? w_rdata : 8'h00;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table, FIFO stall and reset
// sequences, then random traffic against a byte-map / queue reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_cs;
  logic        m_we;
  logic [15:0] m_addr;
  logic [7:0]  m_odata;
  logic [7:0]  m_idata;
  logic        m_wait;
  logic [7:0]  io_in;
  logic [7:0]  io_tx_data;
  logic        io_tx_valid;
  logic        io_tx_ready;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] ref_ram [int];
  logic [7:0] ref_q [$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  din;
    logic [7:0]  exp;
  } vec_t;

  vec_t vt [$];

  mem_ctrl #(
    .ADR_MSB     (15),
    .RAM_AW      (12),
    .WAIT_STATES (1),
    .IO_PAGE     (8'hFF),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .m_cs        (m_cs),
    .m_we        (m_we),
    .m_addr      (m_addr),
    .m_odata     (m_odata),
    .m_idata     (m_idata),
    .m_wait      (m_wait),
    .io_in       (io_in),
    .io_tx_data  (io_tx_data),
    .io_tx_valid (io_tx_valid),
    .io_tx_ready (io_tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // One bus access; cs stays high on return so consecutive calls are back-to-back.
  task automatic access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                        output logic [7:0] rd, output int waits, output bit ok);
    @(negedge clk);
    m_cs = 1'b1; m_we = we; m_addr = addr; m_odata = wd;
    waits = 0; ok = 1'b0; rd = 8'h00;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (!m_wait) begin
        rd = m_idata;
        ok = 1'b1;
        break;
      end
      waits++;
      @(negedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    m_cs = 1'b0; m_we = 1'b0;
  endtask

  function automatic logic [7:0] ref_read(input logic [15:0] a, input logic [7:0] din);
    if (a < 16'h1000) return ref_ram[int'(a)];
    if (a[15:8] == 8'hFF) begin
      if (a[7:0] == 8'h01) return {6'b0, ref_q.size() == 0, ref_q.size() == 4};
      if (a[7:0] == 8'h02) return din;
    end
    return 8'h00;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rd;
    logic [15:0] a;
    logic [7:0]  wd;
    logic        we;
    int          waits;
    bit          ok;
    bit          done;

    rst = 1'b1; m_cs = 1'b1; m_we = 1'b0; m_addr = '0; m_odata = '0;
    io_in = 8'h00; io_tx_ready = 1'b0;

    // Reset state
    #1;
    chk("rst m_wait", 32'(m_wait), 1);
    chk("rst m_idata", 32'(m_idata), 0);
    chk("rst tx_valid", 32'(io_tx_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0; m_cs = 1'b0;
    #1;
    chk("idle m_wait", 32'(m_wait), 0);
    chk("idle tx_valid", 32'(io_tx_valid), 0);
    chk("idle m_idata", 32'(m_idata), 0);

    // Directed vectors: {we, addr, wdata, io_in, expected read}
    vt.push_back('{1'b1, 16'h0123, 8'hA5, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'h0123, 8'h00, 8'h00, 8'hA5});
    vt.push_back('{1'b1, 16'h0010, 8'h34, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'h0011, 8'h12, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'h0010, 8'h00, 8'h00, 8'h34});
    vt.push_back('{1'b0, 16'h0011, 8'h00, 8'h00, 8'h12});
    vt.push_back('{1'b0, 16'h8000, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'h8000, 8'h77, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'h8000, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'h0000, 8'hC3, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'h0FFF, 8'h5A, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'h1000, 8'hEE, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'h0000, 8'h00, 8'h00, 8'hC3});
    vt.push_back('{1'b0, 16'h0FFF, 8'h00, 8'h00, 8'h5A});
    vt.push_back('{1'b0, 16'h1000, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'hFF01, 8'h00, 8'h00, 8'h02});
    vt.push_back('{1'b0, 16'hFF02, 8'h00, 8'h5C, 8'h5C});
    vt.push_back('{1'b0, 16'hFF00, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b1, 16'hFF05, 8'h11, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'hFF05, 8'h00, 8'h00, 8'h00});
    vt.push_back('{1'b0, 16'hFF01, 8'h00, 8'h00, 8'h02});

    foreach (vt[i]) begin
      io_in = vt[i].din;
      access(vt[i].we, vt[i].addr, vt[i].wd, rd, waits, ok);
      chk($sformatf("vec%0d done", i), 32'(ok), 1);
      chk($sformatf("vec%0d waits", i), 32'(waits), 2);
      if (!vt[i].we) chk($sformatf("vec%0d rdata", i), 32'(rd), 32'(vt[i].exp));
    end
    idle();
    chk("after vec tx_valid", 32'(io_tx_valid), 0);

    // Fill the FIFO, then a fifth push stalls until one pop frees a slot
    for (int k = 1; k <= 4; k++) begin
      access(1'b1, 16'hFF00, 8'(k), rd, waits, ok);
      chk($sformatf("fill%0d waits", k), 32'(waits), 2);
    end
    access(1'b0, 16'hFF01, 8'h00, rd, waits, ok);
    chk("full status", 32'(rd), 32'h01);
    @(negedge clk);
    m_cs = 1'b1; m_we = 1'b1; m_addr = 16'hFF00; m_odata = 8'h05;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("stall%0d m_wait", k), 32'(m_wait), 1);
      @(negedge clk);
    end
    io_tx_ready = 1'b1;
    #1;
    chk("stall head", 32'(io_tx_data), 1);
    chk("stall valid", 32'(io_tx_valid), 1);
    @(negedge clk);
    io_tx_ready = 1'b0;
    #1;
    chk("post-pop head", 32'(io_tx_data), 2);
    done = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      #1;
      if (!m_wait) done = 1'b1;
      else @(negedge clk);
    end
    chk("stall release", 32'(done), 1);
    @(negedge clk);
    m_cs = 1'b0; m_we = 1'b0; io_tx_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      #1;
      chk($sformatf("drain%0d valid", k), 32'(io_tx_valid), 1);
      chk($sformatf("drain%0d data", k), 32'(io_tx_data), 32'(k));
      @(negedge clk);
    end
    io_tx_ready = 1'b0;
    #1;
    chk("drained valid", 32'(io_tx_valid), 0);

    // Reset during WAIT of a RAM write: write dropped, FIFO flushed, RAM kept
    access(1'b1, 16'h0040, 8'h11, rd, waits, ok);
    access(1'b1, 16'hFF00, 8'hAB, rd, waits, ok);
    @(negedge clk);
    m_cs = 1'b1; m_we = 1'b1; m_addr = 16'h0040; m_odata = 8'h99;
    @(negedge clk);
    #1;
    chk("pre-rst m_wait", 32'(m_wait), 1);
    chk("pre-rst tx_valid", 32'(io_tx_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid-rst m_wait", 32'(m_wait), 1);
    chk("mid-rst tx_valid", 32'(io_tx_valid), 0);
    chk("mid-rst m_idata", 32'(m_idata), 0);
    @(negedge clk);
    rst = 1'b0; m_cs = 1'b0; m_we = 1'b0;
    #1;
    chk("post-rst m_wait", 32'(m_wait), 0);
    chk("post-rst tx_valid", 32'(io_tx_valid), 0);
    access(1'b0, 16'h0040, 8'h00, rd, waits, ok);
    chk("post-rst ram", 32'(rd), 32'h11);
    chk("post-rst waits", 32'(waits), 2);
    access(1'b0, 16'hFF01, 8'h00, rd, waits, ok);
    chk("post-rst status", 32'(rd), 32'h02);
    idle();

    // Random traffic against the reference model
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind == 9) begin
        @(negedge clk);
        m_cs = 1'b0; m_we = 1'b0;
        io_tx_ready = 1'b1;
        #1;
        if (ref_q.size() != 0) begin
          chk("rnd pop valid", 32'(io_tx_valid), 1);
          chk("rnd pop data", 32'(io_tx_data), 32'(ref_q[0]));
          void'(ref_q.pop_front());
        end else begin
          chk("rnd empty valid", 32'(io_tx_valid), 0);
        end
        @(negedge clk);
        io_tx_ready = 1'b0;
        continue;
      end
      if (kind <= 4) begin
        a  = $urandom_range(0, 1) ? 16'(16'h0200 + $urandom_range(0, 31))
                                  : 16'(16'h0FE0 + $urandom_range(0, 31));
        we = !ref_ram.exists(int'(a)) || 1'($urandom_range(0, 1));
      end else if (kind <= 6) begin
        a  = {8'hFF, 8'($urandom_range(0, 4))};
        we = 1'($urandom_range(0, 1));
        if (we && a[7:0] == 8'h00 && ref_q.size() == 4) we = 1'b0;
      end else begin
        a  = 16'($urandom_range(32'h1000, 32'hFEFF));
        we = 1'($urandom_range(0, 1));
      end
      wd    = 8'($urandom);
      io_in = 8'($urandom);
      access(we, a, wd, rd, waits, ok);
      chk($sformatf("rnd%0d done", n), 32'(ok), 1);
      chk($sformatf("rnd%0d waits", n), 32'(waits), 2);
      if (we) begin
        if (a < 16'h1000) ref_ram[int'(a)] = wd;
        else if (a == 16'hFF00) ref_q.push_back(wd);
      end else begin
        chk($sformatf("rnd%0d rd@%04h", n, a), 32'(rd), 32'(ref_read(a, io_in)));
      end
    end
    idle();

    // Drain whatever the random phase left queued
    io_tx_ready = 1'b1;
    while (ref_q.size() != 0) begin
      #1;
      chk("final drain valid", 32'(io_tx_valid), 1);
      chk("final drain data", 32'(io_tx_data), 32'(ref_q[0]));
      void'(ref_q.pop_front());
      @(negedge clk);
    end
    io_tx_ready = 1'b0;
    #1;
    chk("final empty", 32'(io_tx_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-wide memory/peripheral controller serving the CPU core's 8-bit data bus (m_cs/m_we/m_addr/m_odata in, m_idata/m_wait out).
- Decodes each access to one of three targets:
  - on-chip byte RAM;
  - a small MMIO page with an output-port FIFO and an input port;
  - unmapped space.
- Generates the m_wait stall that the core uses to hold its state machine.
- Sits directly downstream of the core, one instance per core.

Parameters:
- ADR_MSB, 15, MSB of the core address bus.
- RAM_AW, 12, RAM address width. RAM occupies bytes 0 .. 2^RAM_AW-1.
- WAIT_STATES, 1, extra stall cycles per access on top of the mandatory one (0..15).
- IO_PAGE, 8'hFF, value of addr[ADR_MSB:8] that selects the MMIO page.
- FIFO_DEPTH, 4, output FIFO depth, power of two.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- m_cs  in  1  access request from core
- m_we  in  1  1 = write
- m_addr  in  ADR_MSB+1  byte address
- m_odata  in  8  write data from core
- m_idata  out  8  read data to core
- m_wait  out  1  1 = access not complete, core must hold
- io_in  in  8  input port value
- io_tx_data  out  8  FIFO head byte
- io_tx_valid  out  1  FIFO not empty
- io_tx_ready  in  1  consumer pops head when valid & ready

Behaviour:
- Clocking and reset: single clock clk. Reset rst is asynchronous and active-high.
- Reset values: FSM=IDLE, wait counter=0, FIFO empty, io_tx_valid=0, m_idata=8'h00. While rst is high, m_wait=1.
- FSM states: IDLE, WAIT, DONE.
- m_wait is combinational: m_wait = rst | (m_cs & state!=DONE).
- IDLE:
  - If m_cs=0, stay in IDLE.
  - If m_cs=1, register address, we and wdata, and issue the synchronous RAM read.
  - Go to DONE if WAIT_STATES==0, otherwise load counter=WAIT_STATES and go to WAIT.
- WAIT: decrement counter; go to DONE when it reaches 1.
- DONE:
  - m_wait=0 and m_idata holds read data for exactly this cycle.
  - Writes commit at the DONE posedge.
  - Next state is always IDLE.
  - Back-to-back accesses (core LD_BYTE_L then LD_BYTE_H, cs held high) re-enter IDLE and stall again. Minimum 2 cycles per access.
- Latency: a read completes 1+WAIT_STATES cycles after m_cs is first seen. With the default, m_wait is high for 2 cycles and data is valid on the 3rd.
- If m_cs drops while in WAIT, return to IDLE with no side effects and no write.
- Address decode uses the registered address:
  - RAM: addr < 2^RAM_AW.
  - IO: addr[ADR_MSB:8]==IO_PAGE.
  - Otherwise unmapped.
- Unmapped space: reads return 8'h00; writes are dropped.
- MMIO registers (offset = addr[7:0]):
  - 0x00 W: push m_odata into the FIFO. R: returns 0x00.
  - 0x01 R: status. bit0 = FIFO full, bit1 = FIFO empty, other bits 0.
  - 0x02 R: io_in, sampled in the DONE cycle.
  - Other offsets: read 0x00, writes dropped.
- Write to 0x00 while the FIFO is full: the FSM holds in WAIT with m_wait=1 until a slot frees, then proceeds to DONE. The push happens at DONE.
- FIFO rules:
  - Pop when io_tx_valid & io_tx_ready.
  - A simultaneous push and pop when full is allowed: the pop frees a slot in the same cycle and the count stays unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - io_tx_data is don't-care when io_tx_valid=0.
- Reset mid-access: FSM returns to IDLE immediately. A pending write is discarded and the FIFO is flushed. RAM contents are not cleared.

Decomposition:
- Shared package mem_map_pkg holds:
  - the IO page value;
  - register offsets IO_TX=0x00, IO_STAT=0x01, IO_IN=0x02;
  - FSM state encodings.
- Sub-module byte_fifo: parameters DEPTH and WIDTH=8; ports push, pop, din, dout, full, empty; asynchronous reset. Reusable by a future input FIFO.
- RAM is an inferred synchronous array inside mem_ctrl.

Test Plan:
- Reset then idle: m_cs=0 → m_wait=0, io_tx_valid=0, m_idata=0x00. With rst high and m_cs=1 → m_wait=1.
- RAM write/read, WAIT_STATES=1:
  - Write 0xA5 to 0x0123 → m_wait high for exactly 2 cycles.
  - Read 0x0123 → m_idata=0xA5 in the m_wait=0 cycle.
- Back-to-back byte pair with cs held high: read 0x0010 then 0x0011 (preloaded 0x34, 0x12) → two separate 3-cycle accesses returning 0x34 then 0x12.
- Unmapped: read 0x8000 → 0x00. Write 0x77 to 0x8000, then read it back → still 0x00.
- FIFO full stall, io_tx_ready=0:
  - Push 1,2,3,4 to 0xFF00; status read at 0xFF01 = 0x01.
  - 5th write stalls with m_wait=1.
  - Raise io_tx_ready for one cycle → head 1 popped, write completes.
  - FIFO drains in order 2,3,4,5.
- Reset mid-access: assert rst during WAIT of a write to 0x0040 → after release, FSM in IDLE, write absent, FIFO empty.
